// File: rtl/gram_array_ctrl_pkg.sv
// rtl/gram_array_ctrl_pkg.sv - shared constants, FSM states and helpers for the gram array sequencer
package gram_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DIMENSION_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LWAIT,
        RUN,
        FIN
    } gram_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/gram_array_ctrl_edge_skew.sv
// rtl/gram_array_ctrl_edge_skew.sv - one skewed edge lane: picks X[LANE][t-LANE] or 0 and registers it
module gram_edge_skew
    import gram_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DIMENSION = DIMENSION_DEF,
    parameter int LANE      = 0,
    parameter int TW        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [TW-1:0]              t,
    input  logic [DIMENSION*WIDTH-1:0] row,
    output logic [WIDTH-1:0]           elem
);

    logic [WIDTH-1:0] sel;

    // Lane LANE is delayed by LANE cycles, so element k appears at t = k + LANE.
    always_comb begin
        sel = '0;
        for (int k = 0; k < DIMENSION; k++) begin
            if (t == TW'(k + LANE)) sel = row[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            elem <= '0;
        end else begin
            elem <= en ? sel : '0;
        end
    end

endmodule

// File: rtl/gram_array_ctrl.sv
// rtl/gram_array_ctrl.sv - loads X row by row, then feeds a skewed systolic gram array and flags result diagonals
module gram_array_ctrl
    import gram_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DIMENSION  = DIMENSION_DEF,
    localparam int AW        = clog2(DIMENSION),
    localparam int DW        = clog2(2*DIMENSION-1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_ren,
    output logic [AW-1:0]                  mem_addr,
    input  logic [DIMENSION*WIDTH-1:0]     mem_rdata,
    output logic [DIMENSION*WIDTH-1:0]     a_edge,
    output logic [DIMENSION*WIDTH-1:0]     b_edge,
    output logic [DIMENSION*DIMENSION-1:0] pe_en,
    output logic                           res_valid,
    output logic [DW-1:0]                  res_diag
);

    localparam int D  = DIMENSION;
    localparam int TW = clog2(3*D);
    localparam logic [TW-1:0] T_LAST = TW'(3*D-2);

    gram_state_t        state;
    logic [AW-1:0]      lc;
    logic [TW-1:0]      t;
    logic               rd_pend;
    logic [AW-1:0]      rd_row;
    logic [D*WIDTH-1:0] buf_q [D];

    logic [TW-1:0]      t_next;
    logic               feed;
    logic [D*D-1:0]     en_next;

    // Outputs are registered, so everything is computed for the RUN cycle about to begin.
    always_comb begin
        t_next  = (state == RUN) ? t + TW'(1) : '0;
        feed    = (state == LWAIT) || ((state == RUN) && (t != T_LAST));
        en_next = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                en_next[i*D+j] = (t_next >= TW'(i+j)) && (t_next <= TW'(i+j+D-1));
            end
        end
    end

    for (genvar g = 0; g < D; g++) begin : g_lane
        gram_edge_skew #(.WIDTH(WIDTH), .DIMENSION(D), .LANE(g), .TW(TW)) u_a (
            .clk  (clk),
            .rst  (rst),
            .en   (feed),
            .t    (t_next),
            .row  (buf_q[g]),
            .elem (a_edge[g*WIDTH +: WIDTH])
        );
        gram_edge_skew #(.WIDTH(WIDTH), .DIMENSION(D), .LANE(g), .TW(TW)) u_b (
            .clk  (clk),
            .rst  (rst),
            .en   (feed),
            .t    (t_next),
            .row  (buf_q[g]),
            .elem (b_edge[g*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            lc        <= '0;
            t         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            pe_en     <= '0;
            res_valid <= 1'b0;
            res_diag  <= '0;
            rd_pend   <= 1'b0;
            rd_row    <= '0;
            for (int r = 0; r < D; r++) buf_q[r] <= '0;
        end else begin
            done      <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            pe_en     <= '0;
            res_valid <= 1'b0;
            res_diag  <= '0;

            // Read data lags the request by one cycle; land it in the row that was asked for.
            rd_pend <= mem_ren;
            rd_row  <= mem_addr;
            if (rd_pend) buf_q[rd_row] <= mem_rdata;

            if (feed) begin
                pe_en     <= en_next;
                res_valid <= (t_next >= TW'(D));
                res_diag  <= (t_next >= TW'(D)) ? DW'(t_next - TW'(D)) : '0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        lc       <= '0;
                        mem_ren  <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                LOAD: begin
                    if (lc == AW'(D-1)) begin
                        state <= LWAIT;
                    end else begin
                        lc       <= lc + AW'(1);
                        mem_ren  <= 1'b1;
                        mem_addr <= lc + AW'(1);
                    end
                end
                LWAIT: begin
                    state <= RUN;
                    t     <= '0;
                end
                RUN: begin
                    if (t == T_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        t <= t_next;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    lc    <= '0;
                    t     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
